// File: rtl/victim_cache_ctrl_if.sv
// L1 request/response, L2 read/write and LRU-update bundle for victim_cache_ctrl.
// master = surrounding L1/L2/LRU logic, slave = the controller.
interface victim_cache_ctrl_if #(
   parameter int ADDR_W = 27,
   parameter int LINE_W = 256
);
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic              evict_valid;
   logic [ADDR_W-1:0] evict_addr;
   logic [LINE_W-1:0] evict_data;
   logic              evict_dirty;
   logic              resp_valid;
   logic              resp_hit;
   logic              resp_dirty;
   logic [LINE_W-1:0] resp_data;
   logic              l2_read;
   logic              l2_write;
   logic [ADDR_W-1:0] l2_addr;
   logic [LINE_W-1:0] l2_wdata;
   logic [LINE_W-1:0] l2_rdata;
   logic              l2_resp;
   logic              lru_load;
   logic [1:0]        lru_used_way;
   logic [1:0]        lru_way;

   modport master (
      output req_valid, req_addr, evict_valid, evict_addr, evict_data, evict_dirty,
             l2_rdata, l2_resp, lru_way,
      input  req_ready, resp_valid, resp_hit, resp_dirty, resp_data,
             l2_read, l2_write, l2_addr, l2_wdata, lru_load, lru_used_way
   );

   modport slave (
      input  req_valid, req_addr, evict_valid, evict_addr, evict_data, evict_dirty,
             l2_rdata, l2_resp, lru_way,
      output req_ready, resp_valid, resp_hit, resp_dirty, resp_data,
             l2_read, l2_write, l2_addr, l2_wdata, lru_load, lru_used_way
   );
endinterface

// File: rtl/victim_cache_ctrl.sv
// 4-entry fully associative victim cache: tag/data store plus swap/fetch/write-back FSM.
// Optional perf counters (hits, misses, write-backs) enabled by defining VC_PERF_CNT_EN.
//
// state  | meaning
// IDLE   | ready for an L1 miss request; request and victim fields latched on accept
// LOOKUP | tag compare; hit swaps line with victim, miss picks install slot
// WB     | writing displaced dirty line to L2, waiting for l2_resp
// FETCH  | reading requested line from L2, victim installed on l2_resp
// RESP   | raises the one-cycle response, then back to IDLE
module victim_cache_ctrl #(
   parameter int ADDR_W = 27,
   parameter int LINE_W = 256
) (
   input  logic                 clk,
   input  logic                 rst_n,
   victim_cache_ctrl_if.slave   bus
`ifdef VC_PERF_CNT_EN
   ,
   output logic [31:0]          perf_hits,
   output logic [31:0]          perf_misses,
   output logic [31:0]          perf_writebacks
`endif
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOOKUP = 3'd1,
      S_WB     = 3'd2,
      S_FETCH  = 3'd3,
      S_RESP   = 3'd4
   } state_t;

   state_t            state_q;
   logic [3:0]        valid_q;
   logic [3:0]        dirty_q;
   logic [ADDR_W-1:0] tag_q  [4];
   logic [LINE_W-1:0] data_q [4];

   logic [ADDR_W-1:0] req_addr_q;
   logic              ev_valid_q;
   logic [ADDR_W-1:0] ev_addr_q;
   logic [LINE_W-1:0] ev_data_q;
   logic              ev_dirty_q;
   logic [1:0]        slot_q;

   logic              req_ready_q;
   logic              resp_valid_q;
   logic              resp_hit_q;
   logic              resp_dirty_q;
   logic [LINE_W-1:0] resp_data_q;
   logic              l2_read_q;
   logic              l2_write_q;
   logic [ADDR_W-1:0] l2_addr_q;
   logic [LINE_W-1:0] l2_wdata_q;
   logic              lru_load_q;
   logic [1:0]        lru_used_way_q;

   logic              hit;
   logic [1:0]        hit_way;
   logic              free_found;
   logic [1:0]        free_way;
   logic [1:0]        slot;

   always_comb begin
      hit        = 1'b0;
      hit_way    = 2'd0;
      free_found = 1'b0;
      free_way   = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (valid_q[i] && (tag_q[i] == req_addr_q)) begin
            hit     = 1'b1;
            hit_way = 2'(i);
         end
      end
      // scan downwards so the lowest-index free way wins
      for (int i = 3; i >= 0; i--) begin
         if (!valid_q[i]) begin
            free_found = 1'b1;
            free_way   = 2'(i);
         end
      end
      slot = free_found ? free_way : bus.lru_way;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         valid_q        <= '0;
         dirty_q        <= '0;
         for (int i = 0; i < 4; i++) begin
            tag_q[i]  <= '0;
            data_q[i] <= '0;
         end
         req_addr_q     <= '0;
         ev_valid_q     <= 1'b0;
         ev_addr_q      <= '0;
         ev_data_q      <= '0;
         ev_dirty_q     <= 1'b0;
         slot_q         <= 2'd0;
         req_ready_q    <= 1'b1;
         resp_valid_q   <= 1'b0;
         resp_hit_q     <= 1'b0;
         resp_dirty_q   <= 1'b0;
         resp_data_q    <= '0;
         l2_read_q      <= 1'b0;
         l2_write_q     <= 1'b0;
         l2_addr_q      <= '0;
         l2_wdata_q     <= '0;
         lru_load_q     <= 1'b0;
         lru_used_way_q <= 2'd0;
      end else begin
         resp_valid_q <= 1'b0;
         lru_load_q   <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (bus.req_valid) begin
                  req_addr_q  <= bus.req_addr;
                  ev_valid_q  <= bus.evict_valid;
                  ev_addr_q   <= bus.evict_addr;
                  ev_data_q   <= bus.evict_data;
                  ev_dirty_q  <= bus.evict_dirty;
                  req_ready_q <= 1'b0;
                  state_q     <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               if (hit) begin
                  resp_hit_q   <= 1'b1;
                  resp_data_q  <= data_q[hit_way];
                  resp_dirty_q <= dirty_q[hit_way];
                  if (ev_valid_q) begin
                     tag_q[hit_way]   <= ev_addr_q;
                     data_q[hit_way]  <= ev_data_q;
                     dirty_q[hit_way] <= ev_dirty_q;
                     lru_load_q       <= 1'b1;
                     lru_used_way_q   <= hit_way;
                  end else begin
                     valid_q[hit_way] <= 1'b0;
                  end
                  state_q <= S_RESP;
               end else begin
                  resp_hit_q <= 1'b0;
                  slot_q     <= slot;
                  // only a victim displaces anything, and only dirty lines need saving
                  if (ev_valid_q && valid_q[slot] && dirty_q[slot]) begin
                     l2_write_q <= 1'b1;
                     l2_addr_q  <= tag_q[slot];
                     l2_wdata_q <= data_q[slot];
                     state_q    <= S_WB;
                  end else begin
                     l2_read_q <= 1'b1;
                     l2_addr_q <= req_addr_q;
                     state_q   <= S_FETCH;
                  end
               end
            end
            S_WB: begin
               if (bus.l2_resp) begin
                  l2_write_q <= 1'b0;
                  l2_read_q  <= 1'b1;
                  l2_addr_q  <= req_addr_q;
                  state_q    <= S_FETCH;
               end
            end
            S_FETCH: begin
               if (bus.l2_resp) begin
                  l2_read_q    <= 1'b0;
                  resp_data_q  <= bus.l2_rdata;
                  resp_dirty_q <= 1'b0;
                  if (ev_valid_q) begin
                     valid_q[slot_q] <= 1'b1;
                     tag_q[slot_q]   <= ev_addr_q;
                     data_q[slot_q]  <= ev_data_q;
                     dirty_q[slot_q] <= ev_dirty_q;
                     lru_load_q      <= 1'b1;
                     lru_used_way_q  <= slot_q;
                  end
                  state_q <= S_RESP;
               end
            end
            S_RESP: begin
               resp_valid_q <= 1'b1;
               req_ready_q  <= 1'b1;
               state_q      <= S_IDLE;
            end
            default: begin
               req_ready_q <= 1'b1;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready    = req_ready_q;
   assign bus.resp_valid   = resp_valid_q;
   assign bus.resp_hit     = resp_hit_q;
   assign bus.resp_dirty   = resp_dirty_q;
   assign bus.resp_data    = resp_data_q;
   assign bus.l2_read      = l2_read_q;
   assign bus.l2_write     = l2_write_q;
   assign bus.l2_addr      = l2_addr_q;
   assign bus.l2_wdata     = l2_wdata_q;
   assign bus.lru_load     = lru_load_q;
   assign bus.lru_used_way = lru_used_way_q;

`ifdef VC_PERF_CNT_EN
   logic [31:0] perf_hits_q;
   logic [31:0] perf_misses_q;
   logic [31:0] perf_wb_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_hits_q   <= '0;
         perf_misses_q <= '0;
         perf_wb_q     <= '0;
      end else begin
         if (resp_valid_q && resp_hit_q)
            perf_hits_q <= perf_hits_q + 32'd1;
         if (resp_valid_q && !resp_hit_q)
            perf_misses_q <= perf_misses_q + 32'd1;
         if ((state_q == S_WB) && bus.l2_resp)
            perf_wb_q <= perf_wb_q + 32'd1;
      end
   end

   assign perf_hits       = perf_hits_q;
   assign perf_misses     = perf_misses_q;
   assign perf_writebacks = perf_wb_q;
`endif

endmodule

// File: tb/tb_victim_cache_ctrl.sv
// Bench for victim_cache_ctrl: directed scenarios then random transactions,
// each checked against a transaction-level model of the four-way store.
module tb_victim_cache_ctrl;

   localparam int ADDR_W = 27;
   localparam int LINE_W = 256;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   victim_cache_ctrl_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) vif ();

`ifdef VC_PERF_CNT_EN
   logic [31:0] perf_hits;
   logic [31:0] perf_misses;
   logic [31:0] perf_writebacks;
`endif

   victim_cache_ctrl #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (vif)
`ifdef VC_PERF_CNT_EN
      ,
      .perf_hits       (perf_hits),
      .perf_misses     (perf_misses),
      .perf_writebacks (perf_writebacks)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // model of the cache contents
   logic              m_valid [4];
   logic              m_dirty [4];
   logic [ADDR_W-1:0] m_tag   [4];
   logic [LINE_W-1:0] m_data  [4];
   int                m_hits;
   int                m_misses;
   int                m_wbs;

   task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [LINE_W-1:0] rand_line();
      logic [LINE_W-1:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
      return v;
   endfunction

   function automatic bit tag_present(input logic [ADDR_W-1:0] a);
      bit f;
      f = 1'b0;
      for (int i = 0; i < 4; i++) if (m_valid[i] && m_tag[i] == a) f = 1'b1;
      return f;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 4; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
         m_tag[i]   = '0;
         m_data[i]  = '0;
      end
      m_hits = 0;
      m_misses = 0;
      m_wbs = 0;
   endtask

   task automatic run_txn(input logic [ADDR_W-1:0] addr, input logic ev_v,
                          input logic [ADDR_W-1:0] ev_a, input logic [LINE_W-1:0] ev_d,
                          input logic ev_dy, input logic [1:0] lru,
                          input logic [LINE_W-1:0] rdata, input int wlat, input int rlat);
      int                h;
      int                s;
      bit                e_hit, e_dirty, e_wb, e_rd, e_ld;
      logic [ADDR_W-1:0] e_wb_addr;
      logic [LINE_W-1:0] e_wb_data, e_data;
      logic [1:0]        e_ld_way;
      int                e_lat;
      int                cyc, wc, rc, n_wr, n_rd, n_ld, n_ovl;
      bit                got, r_hit, r_dirty;
      logic [LINE_W-1:0] r_data, wb_data;
      logic [ADDR_W-1:0] wb_addr, rd_addr;
      logic [1:0]        ld_way;

      // expected outcome from the cache rules
      h = -1;
      for (int i = 0; i < 4; i++) if (m_valid[i] && m_tag[i] == addr) h = i;
      e_wb = 1'b0; e_rd = 1'b0; e_ld = 1'b0; e_ld_way = 2'd0;
      e_wb_addr = '0; e_wb_data = '0;
      if (h >= 0) begin
         e_hit = 1'b1; e_data = m_data[h]; e_dirty = m_dirty[h]; e_lat = 3;
         if (ev_v) begin
            m_tag[h] = ev_a; m_data[h] = ev_d; m_dirty[h] = ev_dy;
            e_ld = 1'b1; e_ld_way = 2'(h);
         end else begin
            m_valid[h] = 1'b0;
         end
         m_hits++;
      end else begin
         s = -1;
         for (int i = 3; i >= 0; i--) if (!m_valid[i]) s = i;
         if (s < 0) s = int'(lru);
         e_hit = 1'b0; e_data = rdata; e_dirty = 1'b0; e_rd = 1'b1;
         e_wb = ev_v && m_valid[s] && m_dirty[s];
         e_wb_addr = m_tag[s]; e_wb_data = m_data[s];
         e_lat = 3 + rlat + (e_wb ? wlat : 0);
         if (ev_v) begin
            m_valid[s] = 1'b1; m_tag[s] = ev_a; m_data[s] = ev_d; m_dirty[s] = ev_dy;
            e_ld = 1'b1; e_ld_way = 2'(s);
         end
         m_misses++;
         if (e_wb) m_wbs++;
      end

      @(negedge clk);
      chk("req_ready_idle", 256'(vif.req_ready), 256'(1));
      vif.req_valid   = 1'b1;
      vif.req_addr    = addr;
      vif.evict_valid = ev_v;
      vif.evict_addr  = ev_a;
      vif.evict_data  = ev_d;
      vif.evict_dirty = ev_dy;
      vif.lru_way     = lru;
      vif.l2_rdata    = rdata;

      cyc = 0; wc = 0; rc = 0; n_wr = 0; n_rd = 0; n_ld = 0; n_ovl = 0;
      got = 1'b0; r_hit = 1'b0; r_dirty = 1'b0; r_data = '0;
      wb_addr = '0; wb_data = '0; rd_addr = '0; ld_way = 2'd0;
      while (!got && cyc < 200) begin
         @(negedge clk);
         cyc++;
         vif.req_valid = 1'b0;
         vif.l2_resp   = 1'b0;
         if (vif.lru_load) begin
            n_ld++;
            ld_way = vif.lru_used_way;
            if (vif.l2_read || vif.l2_write) n_ovl++;
         end
         if (vif.l2_write) begin
            if (wc == 0) begin
               n_wr++; wb_addr = vif.l2_addr; wb_data = vif.l2_wdata;
            end
            wc++;
            if (wc == wlat) vif.l2_resp = 1'b1;
         end else wc = 0;
         if (vif.l2_read) begin
            if (rc == 0) begin
               n_rd++; rd_addr = vif.l2_addr;
            end
            rc++;
            if (rc == rlat) vif.l2_resp = 1'b1;
         end else rc = 0;
         if (vif.resp_valid) begin
            got = 1'b1; r_hit = vif.resp_hit; r_dirty = vif.resp_dirty; r_data = vif.resp_data;
         end
      end
      vif.l2_resp = 1'b0;

      chk("resp_seen", 256'(got), 256'(1));
      chk("resp_latency", 256'(cyc), 256'(e_lat));
      chk("resp_hit", 256'(r_hit), 256'(e_hit));
      chk("resp_data", 256'(r_data), 256'(e_data));
      chk("resp_dirty", 256'(r_dirty), 256'(e_dirty));
      chk("l2_write_count", 256'(n_wr), 256'(e_wb ? 1 : 0));
      if (e_wb) begin
         chk("wb_addr", 256'(wb_addr), 256'(e_wb_addr));
         chk("wb_data", 256'(wb_data), 256'(e_wb_data));
      end
      chk("l2_read_count", 256'(n_rd), 256'(e_rd ? 1 : 0));
      if (e_rd) chk("rd_addr", 256'(rd_addr), 256'(addr));
      chk("lru_load_count", 256'(n_ld), 256'(e_ld ? 1 : 0));
      if (e_ld) chk("lru_used_way", 256'(ld_way), 256'(e_ld_way));
      chk("lru_l2_overlap", 256'(n_ovl), 256'(0));

      @(negedge clk);
      chk("resp_one_cycle", 256'(vif.resp_valid), 256'(0));
   endtask

   initial begin
      logic [ADDR_W-1:0] a, ea;
      int                nresp, w;

      n_cmp = 0;
      n_err = 0;
      model_clear();
      rst_n           = 1'b0;
      vif.req_valid   = 1'b0;
      vif.req_addr    = '0;
      vif.evict_valid = 1'b0;
      vif.evict_addr  = '0;
      vif.evict_data  = '0;
      vif.evict_dirty = 1'b0;
      vif.l2_rdata    = '0;
      vif.l2_resp     = 1'b0;
      vif.lru_way     = 2'd0;

      repeat (3) @(negedge clk);
      chk("rst_req_ready", 256'(vif.req_ready), 256'(1));
      chk("rst_resp_valid", 256'(vif.resp_valid), 256'(0));
      chk("rst_l2_read", 256'(vif.l2_read), 256'(0));
      chk("rst_l2_write", 256'(vif.l2_write), 256'(0));
      chk("rst_lru_load", 256'(vif.lru_load), 256'(0));
      chk("rst_resp_data", 256'(vif.resp_data), 256'(0));
      chk("rst_l2_addr", 256'(vif.l2_addr), 256'(0));
      rst_n = 1'b1;

      // cold miss, no victim
      run_txn(27'h0000100, 1'b0, '0, '0, 1'b0, 2'd0, {32{8'hA5}}, 1, 4);

      // fill ways 0..3 with victims; 0x12 dirty so it can be written back later
      for (int i = 0; i < 4; i++)
         run_txn(27'h200 + 27'(i), 1'b1, 27'h10 + 27'(i), rand_line(), (i == 2),
                 2'(3 - i), rand_line(), 1, 2);

      // full cache, lru picks dirty way 2
      run_txn(27'h300, 1'b1, 27'h20, rand_line(), 1'b0, 2'd2, rand_line(), 3, 2);
      // hit on way 1 swapping in a dirty victim
      run_txn(27'h11, 1'b1, 27'h30, rand_line(), 1'b1, 2'd0, rand_line(), 1, 1);
      // hit without victim frees way 3, next install must ignore lru_way
      run_txn(27'h13, 1'b0, '0, '0, 1'b0, 2'd0, rand_line(), 1, 1);
      run_txn(27'h400, 1'b1, 27'h40, rand_line(), 1'b0, 2'd0, rand_line(), 1, 3);

      // reset in the middle of a write-back (way 1 holds dirty 0x30)
      @(negedge clk);
      vif.req_valid   = 1'b1;
      vif.req_addr    = 27'h500;
      vif.evict_valid = 1'b1;
      vif.evict_addr  = 27'h501;
      vif.evict_data  = rand_line();
      vif.evict_dirty = 1'b1;
      vif.lru_way     = 2'd1;
      @(negedge clk);
      vif.req_valid = 1'b0;
      w = 0;
      while (!vif.l2_write && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("rst_wb_reached", 256'(vif.l2_write), 256'(1));
      rst_n = 1'b0;
      #1;
      chk("midrst_l2_write", 256'(vif.l2_write), 256'(0));
      chk("midrst_l2_read", 256'(vif.l2_read), 256'(0));
      chk("midrst_req_ready", 256'(vif.req_ready), 256'(1));
      chk("midrst_resp_valid", 256'(vif.resp_valid), 256'(0));
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      nresp = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (vif.resp_valid) nresp++;
      end
      chk("midrst_no_resp", 256'(nresp), 256'(0));
      // previously cached line must now miss
      run_txn(27'h10, 1'b0, '0, '0, 1'b0, 2'd0, rand_line(), 1, 2);

      for (int t = 0; t < 150; t++) begin
         a = 27'h4000000 + 27'($urandom_range(0, 15));
         if ($urandom_range(0, 9) < 7) begin
            do ea = 27'h4000000 + 27'($urandom_range(0, 23));
            while (ea == a || tag_present(ea));
            run_txn(a, 1'b1, ea, rand_line(), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)), rand_line(),
                    int'($urandom_range(1, 5)), int'($urandom_range(1, 5)));
         end else begin
            run_txn(a, 1'b0, '0, '0, 1'b0, 2'($urandom_range(0, 3)), rand_line(),
                    int'($urandom_range(1, 5)), int'($urandom_range(1, 5)));
         end
      end

`ifdef VC_PERF_CNT_EN
      chk("perf_hits", 256'(perf_hits), 256'(m_hits));
      chk("perf_misses", 256'(perf_misses), 256'(m_misses));
      chk("perf_writebacks", 256'(perf_writebacks), 256'(m_wbs));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
